// File: rtl/lint_apb_arb_pkg.sv
// Shared types and constants for the lint-to-APB bridge arbiter.
// Optional response timeout is compiled in with LINT_APB_ARB_TIMEOUT_EN.
package lint_apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RESP = 2'd1,
        DRAIN     = 2'd2
    } arb_state_e;

    localparam logic [31:0] TIMEOUT_ERR_RDATA = 32'hBADACCE5;

    function automatic int unsigned owner_width(input int unsigned n_master);
        return (n_master > 1) ? $clog2(n_master) : 1;
    endfunction

endpackage

// File: rtl/lint_rr_picker.sv
// Round-robin priority search: first set request at or above i_rr_ptr, wrapping.
// Purely combinational, zero latency; no backpressure of its own.
module lint_rr_picker
    import lint_apb_arb_pkg::*;
#(
    parameter int unsigned N_MASTER = 4,
    parameter int unsigned OW       = owner_width(N_MASTER)
) (
    input  logic [N_MASTER-1:0] i_req,
    input  logic [OW-1:0]       i_rr_ptr,
    output logic [OW-1:0]       o_idx,
    output logic                o_vld
);

    int          w_cand;
    logic [OW-1:0] w_cand_idx;

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        o_idx      = '0;
        o_vld      = 1'b0;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int k = int'(N_MASTER) - 1; k >= 0; k--) begin
            w_cand = int'(i_rr_ptr) + k;
            if (w_cand >= int'(N_MASTER)) begin
                w_cand = w_cand - int'(N_MASTER);
            end
            w_cand_idx = OW'(w_cand);
            if (i_req[w_cand_idx]) begin
                o_idx = w_cand_idx;
                o_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lint_apb_arbiter.sv
// Round-robin arbiter sharing one lint bridge port among N_MASTER requesters, one transaction in flight.
// Grant and response are combinational pass-through (0 added cycles); requesters stall until the bridge grants.
// Optional LINT_APB_ARB_TIMEOUT_EN: error response after TIMEOUT_CYCLES, late bridge response drained.
module lint_apb_arbiter
    import lint_apb_arb_pkg::*;
#(
    parameter int unsigned N_MASTER       = 4,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BE_WIDTH       = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH       = 10,
    parameter int unsigned AUX_WIDTH      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                                 clk,
    input  logic                                 rst_n,

    input  logic [N_MASTER-1:0]                  data_req_i,
    input  logic [N_MASTER-1:0][ADDR_WIDTH-1:0]  data_add_i,
    input  logic [N_MASTER-1:0]                  data_wen_i,
    input  logic [N_MASTER-1:0][DATA_WIDTH-1:0]  data_wdata_i,
    input  logic [N_MASTER-1:0][BE_WIDTH-1:0]    data_be_i,
    input  logic [N_MASTER-1:0][AUX_WIDTH-1:0]   data_aux_i,
    input  logic [N_MASTER-1:0][ID_WIDTH-1:0]    data_ID_i,
    output logic [N_MASTER-1:0]                  data_gnt_o,
    output logic [N_MASTER-1:0]                  data_r_valid_o,
    output logic [DATA_WIDTH-1:0]                data_r_rdata_o,
    output logic                                 data_r_opc_o,
    output logic [AUX_WIDTH-1:0]                 data_r_aux_o,
    output logic [ID_WIDTH-1:0]                  data_r_ID_o,

    output logic                                 bridge_req_o,
    output logic [ADDR_WIDTH-1:0]                bridge_add_o,
    output logic                                 bridge_wen_o,
    output logic [DATA_WIDTH-1:0]                bridge_wdata_o,
    output logic [BE_WIDTH-1:0]                  bridge_be_o,
    output logic [AUX_WIDTH-1:0]                 bridge_aux_o,
    output logic [ID_WIDTH-1:0]                  bridge_ID_o,
    input  logic                                 bridge_gnt_i,
    input  logic                                 bridge_r_valid_i,
    input  logic [DATA_WIDTH-1:0]                bridge_r_rdata_i,
    input  logic                                 bridge_r_opc_i,
    input  logic [AUX_WIDTH-1:0]                 bridge_r_aux_i,
    input  logic [ID_WIDTH-1:0]                  bridge_r_ID_i
);

    localparam int unsigned OW = owner_width(N_MASTER);

    arb_state_e    r_state;
    logic [OW-1:0] r_owner;
    logic [OW-1:0] r_rr_ptr;

    logic [OW-1:0] w_win_idx;
    logic          w_win_vld;
    logic          w_grant;
    logic          w_rsp_pass;
    logic          w_tmo_fire;
    logic [OW-1:0] w_next_ptr;

    lint_rr_picker #(
        .N_MASTER (N_MASTER),
        .OW       (OW)
    ) u_picker (
        .i_req    (data_req_i),
        .i_rr_ptr (r_rr_ptr),
        .o_idx    (w_win_idx),
        .o_vld    (w_win_vld)
    );

    assign w_grant    = (r_state == IDLE) && w_win_vld && bridge_gnt_i;
    assign w_rsp_pass = (r_state == WAIT_RESP) && bridge_r_valid_i;
    assign w_next_ptr = (r_owner == OW'(N_MASTER - 1)) ? '0 : r_owner + 1'b1;

    assign bridge_req_o   = (r_state == IDLE) && (|data_req_i);
    assign bridge_add_o   = data_add_i[w_win_idx];
    assign bridge_wen_o   = data_wen_i[w_win_idx];
    assign bridge_wdata_o = data_wdata_i[w_win_idx];
    assign bridge_be_o    = data_be_i[w_win_idx];
    assign bridge_aux_o   = data_aux_i[w_win_idx];
    assign bridge_ID_o    = data_ID_i[w_win_idx];

`ifdef LINT_APB_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0]     r_tmo_cnt;
    logic [AUX_WIDTH-1:0] r_cap_aux;
    logic [ID_WIDTH-1:0]  r_cap_id;

    // A real bridge response on the deadline cycle takes precedence over the error.
    assign w_tmo_fire = (r_state == WAIT_RESP) && !bridge_r_valid_i
                        && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_cfg;

    assign w_tmo_fire   = 1'b0;
    assign w_unused_cfg = (TIMEOUT_CYCLES != 0) ^ (^TIMEOUT_ERR_RDATA);
`endif

    always_comb begin
        data_gnt_o     = '0;
        data_r_valid_o = '0;
        data_r_rdata_o = '0;
        data_r_opc_o   = 1'b0;
        data_r_aux_o   = '0;
        data_r_ID_o    = '0;
        if (w_grant) begin
            data_gnt_o[w_win_idx] = 1'b1;
        end
        if (w_rsp_pass) begin
            data_r_valid_o[r_owner] = 1'b1;
            data_r_rdata_o          = bridge_r_rdata_i;
            data_r_opc_o            = bridge_r_opc_i;
            data_r_aux_o            = bridge_r_aux_i;
            data_r_ID_o             = bridge_r_ID_i;
        end
`ifdef LINT_APB_ARB_TIMEOUT_EN
        else if (w_tmo_fire) begin
            data_r_valid_o[r_owner] = 1'b1;
            data_r_rdata_o          = DATA_WIDTH'(TIMEOUT_ERR_RDATA);
            data_r_opc_o            = 1'b1;
            data_r_aux_o            = r_cap_aux;
            data_r_ID_o             = r_cap_id;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
`ifdef LINT_APB_ARB_TIMEOUT_EN
            r_tmo_cnt <= '0;
            r_cap_aux <= '0;
            r_cap_id  <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_owner <= w_win_idx;
                        r_state <= WAIT_RESP;
`ifdef LINT_APB_ARB_TIMEOUT_EN
                        r_tmo_cnt <= '0;
                        r_cap_aux <= data_aux_i[w_win_idx];
                        r_cap_id  <= data_ID_i[w_win_idx];
`endif
                    end
                end
                WAIT_RESP: begin
                    if (bridge_r_valid_i) begin
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= IDLE;
                    end else if (w_tmo_fire) begin
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= DRAIN;
                    end
`ifdef LINT_APB_ARB_TIMEOUT_EN
                    else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end
                DRAIN: begin
`ifdef LINT_APB_ARB_TIMEOUT_EN
                    // The bridge still owes one response for the timed-out request; swallow it.
                    if (bridge_r_valid_i) begin
                        r_state <= IDLE;
                    end
`else
                    r_state <= IDLE;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
